pipe_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline (F, D, E, M, WB) around the F/D, D/Ex and Ex/M latches.
//  - Generates the latch enables, flushes (bubbles) and PC control.
//  - Detects load-use and RAW hazards, and produces the E-stage operand forwarding selects.
//  - Freezes the pipe on memory wait.
//  - Drains the pipe and vectors on an interrupt.

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for a 5-stage pipeline: latch enables, flushes, PC control,
// E-stage forwarding selects and interrupt drain. Define FWD_EN to enable operand forwarding.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW    = 2,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] d_ra_i,
    input  logic [REG_AW-1:0] d_rb_i,
    input  logic              d_use_a_i,
    input  logic              d_use_b_i,
    input  logic [REG_AW-1:0] e_ra_i,
    input  logic [REG_AW-1:0] e_rb_i,
    input  logic [REG_AW-1:0] e_rd_i,
    input  logic              e_rw_i,
    input  logic              e_mr_i,
    input  logic              e_br_taken_i,
    input  logic [REG_AW-1:0] m_rd_i,
    input  logic              m_rw_i,
    input  logic [REG_AW-1:0] w_rd_i,
    input  logic              w_rw_i,
    input  logic              mem_busy_i,
    input  logic              irq_i,
    output logic              pc_en_o,
    output logic              pc_vec_o,
    output logic              fd_en_o,
    output logic              fd_flush_o,
    output logic              de_en_o,
    output logic              de_flush_o,
    output logic              em_en_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              int_ack_o
);

    typedef enum logic [1:0] {StRun, StDrain, StVector} state_e;

    localparam logic [2:0] CntInit = 3'(DRAIN_CYC - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       load_use;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;

    assign load_use = e_mr_i & e_rw_i &
                      ((d_use_a_i & (d_ra_i == e_rd_i)) | (d_use_b_i & (d_rb_i == e_rd_i)));

`ifdef FWD_EN
    assign stall = load_use;

    // M-stage result is younger than WB, so it takes precedence.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (m_rw_i && (m_rd_i == e_ra_i)) begin
            fwd_a = 2'b01;
        end else if (w_rw_i && (w_rd_i == e_ra_i)) begin
            fwd_a = 2'b10;
        end
        if (m_rw_i && (m_rd_i == e_rb_i)) begin
            fwd_b = 2'b01;
        end else if (w_rw_i && (w_rd_i == e_rb_i)) begin
            fwd_b = 2'b10;
        end
    end
`else
    logic raw_e, raw_m;
    logic unused_fwd;

    // Without forwarding, hold D until its producers reach WB (write-first regfile).
    assign raw_e = e_rw_i &
                   ((d_use_a_i & (d_ra_i == e_rd_i)) | (d_use_b_i & (d_rb_i == e_rd_i)));
    assign raw_m = m_rw_i &
                   ((d_use_a_i & (d_ra_i == m_rd_i)) | (d_use_b_i & (d_rb_i == m_rd_i)));
    assign stall = raw_e | raw_m | load_use;
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign unused_fwd = ^{e_ra_i, e_rb_i, w_rd_i, w_rw_i};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en_o    = 1'b1;
        pc_vec_o   = 1'b0;
        fd_en_o    = 1'b1;
        fd_flush_o = 1'b0;
        de_en_o    = 1'b1;
        de_flush_o = 1'b0;
        em_en_o    = 1'b1;
        int_ack_o  = 1'b0;
        fwd_a_o    = fwd_a;
        fwd_b_o    = fwd_b;

        if (!rst_ni) begin
            pc_en_o    = 1'b0;
            fd_en_o    = 1'b0;
            de_en_o    = 1'b0;
            em_en_o    = 1'b0;
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
            fwd_a_o    = 2'b00;
            fwd_b_o    = 2'b00;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_busy_i) begin
                        pc_en_o = 1'b0;
                        fd_en_o = 1'b0;
                        de_en_o = 1'b0;
                        em_en_o = 1'b0;
                    end else if (e_br_taken_i) begin
                        fd_flush_o = 1'b1;
                        de_flush_o = 1'b1;
                    end else if (stall) begin
                        pc_en_o    = 1'b0;
                        fd_en_o    = 1'b0;
                        de_flush_o = 1'b1;
                    end else if (irq_i) begin
                        pc_en_o    = 1'b0;
                        fd_flush_o = 1'b1;
                        state_d    = StDrain;
                        cnt_d      = CntInit;
                    end
                end
                StDrain: begin
                    // A taken branch while draining updates the saved return PC.
                    pc_en_o    = e_br_taken_i;
                    fd_flush_o = 1'b1;
                    de_flush_o = 1'b1;
                    if (mem_busy_i) begin
                        pc_en_o = 1'b0;
                        fd_en_o = 1'b0;
                        de_en_o = 1'b0;
                        em_en_o = 1'b0;
                    end else if (cnt_q == 3'd0) begin
                        state_d = StVector;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StVector: begin
                    pc_vec_o   = 1'b1;
                    fd_flush_o = 1'b1;
                    if (mem_busy_i) begin
                        pc_en_o = 1'b0;
                        fd_en_o = 1'b0;
                        de_en_o = 1'b0;
                        em_en_o = 1'b0;
                    end else begin
                        int_ack_o = 1'b1;
                        state_d   = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

endmodule
